score_bcd_display: RTL and testbench

SCORE_BCD_DISPLAY -- requirements
Module: score_bcd_display

---
 rtl/score_pkg.sv | 33 +++
 rtl/bcd_digit.sv | 40 ++++
 rtl/score_bcd_display.sv | 135 +++++++++++++
 tb/tb_score_bcd_display.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared definitions for the BCD score display.
//   SEG_BLANK  : all segments off (active-low segment bus)
//   SEG_TABLE  : BCD digit 0-9 -> active-low segment pattern, bit 0 = segment a
//   MAX_DIGITS : largest supported score width in BCD digits
//   seg_of()   : table lookup; codes above 9 decode to blank
package score_pkg;

  localparam int MAX_DIGITS = 6;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Index 0 is the rightmost entry.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    if (d <= 4'd9) begin
      return SEG_TABLE[d];
    end
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the score counter.
//   clk       : clock
//   rst_n     : synchronous active-low reset (digit -> 0)
//   clr       : synchronous clear (digit -> 0), below reset in priority
//   inc       : increment request for the whole score
//   carry_in  : all lower digits are 9 (tied high for the least-significant digit)
//   carry_out : this digit and all lower digits are 9
//   digit_q   : current digit value
//   digit_d   : value the digit takes at the next edge (if not in reset)
module bcd_digit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic       carry_in,
  output logic       carry_out,
  output logic [3:0] digit_q,
  output logic [3:0] digit_d
);

  assign carry_out = carry_in && (digit_q == 4'd9);

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = 4'd0;
    end else if (inc && carry_in) begin
      digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/score_bcd_display.sv
// Saturating BCD score counter with high-score tracking and a registered,
// leading-zero-blanked seven-segment display.
//   CLK_50M     : clock
//   RSTn        : synchronous active-low reset
//   add_cube    : add-point level; each rising edge adds one point
//   clear_score : zero the current score (high score kept)
//   show_hi     : display high score (1) or current score (0)
//   hex         : active-low segments, digit i at [7i+6:7i]
//   score_bcd   : current score, packed BCD
//   hi_bcd      : high score, packed BCD
//   saturated   : score is all nines
module score_bcd_display
  import score_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic                  CLK_50M,
  input  logic                  RSTn,
  input  logic                  add_cube,
  input  logic                  clear_score,
  input  logic                  show_hi,
  output logic [7*DIGITS-1:0]   hex,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   hi_bcd,
  output logic                  saturated
);

  logic                  add_prev_q;
  logic                  rise;
  logic                  inc;
  logic                  score_max;
  logic [4*DIGITS-1:0]   score_q;
  logic [4*DIGITS-1:0]   score_d;
  logic [4*DIGITS-1:0]   all_nines;
  logic [4*DIGITS-1:0]   hi_q;
  logic                  score_gt_hi;
  logic                  saturated_q;
  logic [4*DIGITS-1:0]   disp_sel;
  logic [7*DIGITS-1:0]   hex_q;
  logic [7*DIGITS-1:0]   hex_d;
  logic [7*DIGITS-1:0]   hex_rst;

  assign rise = add_cube && !add_prev_q;
  // A rise while at all-nines is dropped rather than wrapping the counter.
  assign inc  = rise && !score_max;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic cin;
      logic cout;
      if (gi == 0) begin : g_lsd
        assign cin = 1'b1;
      end else begin : g_upper
        assign cin = g_digit[gi-1].cout;
      end

      bcd_digit u_digit (
        .clk       (CLK_50M),
        .rst_n     (RSTn),
        .clr       (clear_score),
        .inc       (inc),
        .carry_in  (cin),
        .carry_out (cout),
        .digit_q   (score_q[4*gi +: 4]),
        .digit_d   (score_d[4*gi +: 4])
      );

      assign all_nines[4*gi +: 4] = 4'd9;
      assign hex_rst[7*gi +: 7]   = (gi == 0 || BLANK_LZ == 0) ? seg_of(4'd0) : SEG_BLANK;
    end
  endgenerate

  // Carry out of the top digit is set exactly when every digit is 9.
  assign score_max = g_digit[DIGITS-1].cout;

  // Magnitude compare, most-significant digit first: the first differing
  // digit decides.
  always_comb begin
    logic decided;
    score_gt_hi = 1'b0;
    decided     = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (!decided && (score_q[4*i +: 4] != hi_q[4*i +: 4])) begin
        decided     = 1'b1;
        score_gt_hi = score_q[4*i +: 4] > hi_q[4*i +: 4];
      end
    end
  end

  assign disp_sel = show_hi ? hi_q : score_q;

  // Walk from the top digit down; a digit is blanked while it and every
  // digit above it are zero. Digit 0 always shows.
  always_comb begin
    logic       all_zero;
    logic [3:0] d;
    hex_d    = '0;
    all_zero = 1'b1;
    d        = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d        = disp_sel[4*i +: 4];
      all_zero = all_zero && (d == 4'd0);
      if ((BLANK_LZ != 0) && (i > 0) && all_zero) begin
        hex_d[7*i +: 7] = SEG_BLANK;
      end else begin
        hex_d[7*i +: 7] = seg_of(d);
      end
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (!RSTn) begin
      add_prev_q  <= 1'b1;  // a level held high across reset release is not a rise
      hi_q        <= '0;
      saturated_q <= 1'b0;
      hex_q       <= hex_rst;
    end else begin
      add_prev_q  <= add_cube;
      if (score_gt_hi) begin
        hi_q <= score_q;
      end
      // Compare the next score so the flag rises on the same edge as the score.
      saturated_q <= (score_d == all_nines);
      hex_q       <= hex_d;
    end
  end

  assign score_bcd = score_q;
  assign hi_bcd    = hi_q;
  assign saturated = saturated_q;
  assign hex       = hex_q;

endmodule

// File: tb/tb_score_bcd_display.sv
module tb_score_bcd_display;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        add_cube;
  logic        add3;
  logic        clear_score;
  logic        show_hi;
  logic [13:0] hex;
  logic [7:0]  score_bcd;
  logic [7:0]  hi_bcd;
  logic        saturated;
  logic [20:0] hex3;
  logic [11:0] score3;
  logic [11:0] hi3;
  logic        sat3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  score_bcd_display #(.DIGITS(2), .BLANK_LZ(1)) dut (
    .CLK_50M     (clk),
    .RSTn        (rstn),
    .add_cube    (add_cube),
    .clear_score (clear_score),
    .show_hi     (show_hi),
    .hex         (hex),
    .score_bcd   (score_bcd),
    .hi_bcd      (hi_bcd),
    .saturated   (saturated)
  );

  score_bcd_display #(.DIGITS(3), .BLANK_LZ(1)) dut3 (
    .CLK_50M     (clk),
    .RSTn        (rstn),
    .add_cube    (add3),
    .clear_score (clear_score),
    .show_hi     (1'b0),
    .hex         (hex3),
    .score_bcd   (score3),
    .hi_bcd      (hi3),
    .saturated   (sat3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n, input bit third);
    for (int k = 0; k < n; k++) begin
      if (third) add3 = 1'b1; else add_cube = 1'b1;
      tick();
      if (third) add3 = 1'b0; else add_cube = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; add_cube = 1'b1; add3 = 1'b0; clear_score = 1'b0; show_hi = 1'b0;
    tick(); tick();
    checks++;
    if ({score_bcd, hi_bcd, saturated} !== 17'h0) begin
      failures++;
      $display("FAIL reset_regs got score=%h hi=%h sat=%b want 00 00 0", score_bcd, hi_bcd, saturated);
    end
    checks++;
    if (hex !== {BL, S0}) begin
      failures++;
      $display("FAIL reset_hex got %b want %b", hex, {BL, S0});
    end
    // Release with add_cube still high and hold it 5 cycles: no point counted.
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (score_bcd !== 8'h00) begin
      failures++;
      $display("FAIL held_add_after_reset got score=%h want 00", score_bcd);
    end
    checks++;
    if (hex !== {BL, S0}) begin
      failures++;
      $display("FAIL held_add_hex got %b want %b", hex, {BL, S0});
    end
    add_cube = 1'b0;
    tick();
    $display("test_reset done score=%h hex=%b", score_bcd, hex);
  endtask

  task automatic test_count12();
    pulses(11, 1'b0);
    add_cube = 1'b1;
    tick();
    checks++;
    if (score_bcd !== 8'h12 || hi_bcd !== 8'h11) begin
      failures++;
      $display("FAIL count12_edge got score=%h hi=%h want 12 11", score_bcd, hi_bcd);
    end
    add_cube = 1'b0;
    tick();
    checks++;
    if (hi_bcd !== 8'h12) begin
      failures++;
      $display("FAIL count12_hi_lag got hi=%h want 12", hi_bcd);
    end
    checks++;
    if (hex !== {S1, S2}) begin
      failures++;
      $display("FAIL count12_hex got %b want %b", hex, {S1, S2});
    end
    $display("test_count12 done score=%h hi=%h", score_bcd, hi_bcd);
  endtask

  task automatic test_clear_and_show_hi();
    pulses(25, 1'b0);
    checks++;
    if (score_bcd !== 8'h37 || hi_bcd !== 8'h37) begin
      failures++;
      $display("FAIL reach37 got score=%h hi=%h want 37 37", score_bcd, hi_bcd);
    end
    clear_score = 1'b1; add_cube = 1'b1;
    tick();
    clear_score = 1'b0;
    checks++;
    if (score_bcd !== 8'h00 || hi_bcd !== 8'h37) begin
      failures++;
      $display("FAIL clear_priority got score=%h hi=%h want 00 37", score_bcd, hi_bcd);
    end
    tick(); tick(); tick();
    checks++;
    if (score_bcd !== 8'h00) begin
      failures++;
      $display("FAIL clear_no_replay got score=%h want 00", score_bcd);
    end
    add_cube = 1'b0;
    tick();
    pulses(5, 1'b0);
    checks++;
    if (score_bcd !== 8'h05 || hi_bcd !== 8'h37) begin
      failures++;
      $display("FAIL reach05 got score=%h hi=%h want 05 37", score_bcd, hi_bcd);
    end
    show_hi = 1'b1;
    tick();
    checks++;
    if (hex !== {S3, S7}) begin
      failures++;
      $display("FAIL show_hi_hex got %b want %b", hex, {S3, S7});
    end
    show_hi = 1'b0;
    tick();
    checks++;
    if (hex !== {BL, S5}) begin
      failures++;
      $display("FAIL show_score_hex got %b want %b", hex, {BL, S5});
    end
    $display("test_clear_and_show_hi done score=%h hi=%h", score_bcd, hi_bcd);
  endtask

  task automatic test_saturate();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    pulses(98, 1'b0);
    checks++;
    if (score_bcd !== 8'h98 || saturated !== 1'b0) begin
      failures++;
      $display("FAIL reach98 got score=%h sat=%b want 98 0", score_bcd, saturated);
    end
    add_cube = 1'b1;
    tick();
    checks++;
    if (score_bcd !== 8'h99 || saturated !== 1'b1) begin
      failures++;
      $display("FAIL sat_same_edge got score=%h sat=%b want 99 1", score_bcd, saturated);
    end
    add_cube = 1'b0;
    tick();
    pulses(2, 1'b0);
    checks++;
    if (score_bcd !== 8'h99 || saturated !== 1'b1 || hi_bcd !== 8'h99) begin
      failures++;
      $display("FAIL sat_hold got score=%h sat=%b hi=%h want 99 1 99", score_bcd, saturated, hi_bcd);
    end
    checks++;
    if (hex !== {S9, S9}) begin
      failures++;
      $display("FAIL sat_hex got %b want %b", hex, {S9, S9});
    end
    $display("test_saturate done score=%h sat=%b", score_bcd, saturated);
  endtask

  task automatic test_reset_priority();
    rstn = 1'b0; clear_score = 1'b1; add_cube = 1'b1;
    tick();
    checks++;
    if ({score_bcd, hi_bcd, saturated} !== 17'h0 || hex !== {BL, S0}) begin
      failures++;
      $display("FAIL reset_priority got score=%h hi=%h sat=%b hex=%b want 00 00 0 %b",
               score_bcd, hi_bcd, saturated, hex, {BL, S0});
    end
    clear_score = 1'b0; rstn = 1'b1;
    tick(); tick();
    checks++;
    if (score_bcd !== 8'h00) begin
      failures++;
      $display("FAIL reset_no_count got score=%h want 00", score_bcd);
    end
    add_cube = 1'b0;
    tick();
    $display("test_reset_priority done score=%h", score_bcd);
  endtask

  task automatic test_digits3();
    pulses(9, 1'b1);
    checks++;
    if (score3 !== 12'h009 || hex3 !== {BL, BL, S9}) begin
      failures++;
      $display("FAIL d3_nine got score=%h hex=%b want 009 %b", score3, hex3, {BL, BL, S9});
    end
    pulses(100, 1'b1);
    checks++;
    if (score3 !== 12'h109 || hi3 !== 12'h109 || sat3 !== 1'b0) begin
      failures++;
      $display("FAIL d3_109 got score=%h hi=%h sat=%b want 109 109 0", score3, hi3, sat3);
    end
    checks++;
    if (hex3 !== {S1, S0, S9}) begin
      failures++;
      $display("FAIL d3_hex got %b want %b", hex3, {S1, S0, S9});
    end
    $display("test_digits3 done score=%h hex=%b", score3, hex3);
  endtask

  initial begin
    test_reset();
    test_count12();
    test_clear_and_show_hi();
    test_saturate();
    test_reset_priority();
    test_digits3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
